ysyx_23060025_mdu: RTL

Iterative RV32M multiply/divide unit with its own sequencing FSM, placed beside the EX-stage ALU. When EX holds an M-extension instruction, EX presents the operands here and holds its `es_ready_go` low until this block returns a result through a valid/ready response handshake. One operation is in flight at a time. Both multiply and divide take a fixed 32 iterations; divide-by-zero and signed overflow take a one-cycle fast path.

---
 rtl/ysyx_23060025_mdu_if.sv | 28 ++
 rtl/ysyx_23060025_mdu.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_mdu_if.sv
// EX <-> MDU request/response bundle: request handshake with operands,
// a kill line, and a valid/ready response carrying the result.
interface ysyx_23060025_mdu_if #(
  parameter int DATA_LEN = 32
);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [2:0]          op_i;
  logic [DATA_LEN-1:0] src1_i;
  logic [DATA_LEN-1:0] src2_i;
  logic                kill_i;
  logic                resp_valid_o;
  logic                resp_ready_i;
  logic [DATA_LEN-1:0] result_o;
  logic                busy_o;

  // EX stage side
  modport master (
    output req_valid_i, op_i, src1_i, src2_i, kill_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, result_o, busy_o
  );

  // Multiply/divide unit side
  modport slave (
    input  req_valid_i, op_i, src1_i, src2_i, kill_i, resp_ready_i,
    output req_ready_o, resp_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/ysyx_23060025_mdu.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, 32-step
// restoring divide, single-cycle path for divide-by-zero and signed overflow.
module ysyx_23060025_mdu #(
  parameter int DATA_LEN = 32
) (
  input logic                  clock,
  input logic                  reset,
  ysyx_23060025_mdu_if.slave   mdu
);

  localparam int W = DATA_LEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e             r_state;
  state_e             w_next;
  logic [4:0]         r_cnt;
  logic [W-1:0]       r_result;
  logic [1:0]         r_op;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [2*W-1:0]     r_mcand;
  logic [W-1:0]       r_mplier;
  logic [2*W-1:0]     r_prod;
  logic [W-1:0]       r_rem;
  logic [W-1:0]       r_quo;
  logic [W-1:0]       r_divisor;

  logic               w_accept;
  logic               w_last;
  logic               w_s1_signed;
  logic               w_s2_signed;
  logic               w_src1_neg;
  logic               w_src2_neg;
  logic [W-1:0]       w_mag1;
  logic [W-1:0]       w_mag2;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic               w_fast;
  logic [W-1:0]       w_fast_result;
  logic [2*W-1:0]     w_prod_step;
  logic [2*W-1:0]     w_prod_fin;
  logic [W-1:0]       w_mul_word;
  logic [W:0]         w_shift;
  logic               w_ge;
  logic [W-1:0]       w_rem_step;
  logic [W-1:0]       w_quo_step;
  logic [W-1:0]       w_div_word;

  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

  // ---------------- request decode ----------------
  assign w_accept    = (r_state == S_IDLE) && mdu.req_valid_i && !mdu.kill_i;
  assign w_last      = (r_cnt == 5'(W - 1));

  // src1 is signed for MULH, MULHSU, DIV, REM; src2 for MULH, DIV, REM
  assign w_s1_signed = (mdu.op_i == 3'b001) || (mdu.op_i == 3'b010) ||
                       (mdu.op_i == 3'b100) || (mdu.op_i == 3'b110);
  assign w_s2_signed = (mdu.op_i == 3'b001) || (mdu.op_i == 3'b100) ||
                       (mdu.op_i == 3'b110);
  assign w_src1_neg  = w_s1_signed && mdu.src1_i[W-1];
  assign w_src2_neg  = w_s2_signed && mdu.src2_i[W-1];
  assign w_mag1      = w_src1_neg ? -mdu.src1_i : mdu.src1_i;
  assign w_mag2      = w_src2_neg ? -mdu.src2_i : mdu.src2_i;

  assign w_div_zero  = mdu.op_i[2] && (mdu.src2_i == '0);
  assign w_div_ovf   = mdu.op_i[2] && !mdu.op_i[0] &&
                       (mdu.src1_i == MIN_INT) && (mdu.src2_i == ALL_ONE);
  assign w_fast      = w_div_zero || w_div_ovf;
  assign w_fast_result = w_div_zero ? (mdu.op_i[1] ? mdu.src1_i : ALL_ONE)
                                    : (mdu.op_i[1] ? '0 : MIN_INT);

  // ---------------- iteration datapath ----------------
  assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_prod_fin  = r_neg_res ? -w_prod_step : w_prod_step;
  assign w_mul_word  = (r_op == 2'b00) ? w_prod_fin[W-1:0] : w_prod_fin[2*W-1:W];

  // Partial remainder stays below the divisor, so the 32-bit subtract is exact
  assign w_shift     = {r_rem, r_quo[W-1]};
  assign w_ge        = (w_shift >= {1'b0, r_divisor});
  assign w_rem_step  = w_ge ? (w_shift[W-1:0] - r_divisor) : w_shift[W-1:0];
  assign w_quo_step  = {r_quo[W-2:0], w_ge};
  assign w_div_word  = r_op[1] ? (r_neg_rem ? -w_rem_step : w_rem_step)
                               : (r_neg_res ? -w_quo_step : w_quo_step);

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: next state takes its default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = w_fast ? S_DONE : (mdu.op_i[2] ? S_DIV : S_MUL);
      S_MUL,
      S_DIV:  if (w_last) w_next = S_DONE;
      S_DONE: if (mdu.resp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (mdu.kill_i) w_next = S_IDLE;
  end

  // NOTE: state-holding registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (w_fast) r_result <= w_fast_result;
    end else if (!mdu.kill_i && (r_state == S_MUL || r_state == S_DIV)) begin
      r_cnt <= r_cnt + 5'd1;
      if (w_last) r_result <= (r_state == S_MUL) ? w_mul_word : w_div_word;
    end
  end

  // NOTE: operand/working registers are always loaded on accept before use, so they carry no reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_op      <= mdu.op_i[1:0];
      r_neg_res <= w_src1_neg ^ w_src2_neg;
      r_neg_rem <= w_src1_neg;
      r_mcand   <= {{W{1'b0}}, w_mag1};
      r_mplier  <= w_mag2;
      r_prod    <= '0;
      r_rem     <= '0;
      r_quo     <= w_mag1;
      r_divisor <= w_mag2;
    end else if (r_state == S_MUL) begin
      r_prod   <= w_prod_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_step;
      r_quo <= w_quo_step;
    end
  end

  // Handshake flags decode state only; no input reaches them combinationally
  assign mdu.req_ready_o  = (r_state == S_IDLE);
  assign mdu.resp_valid_o = (r_state == S_DONE);
  assign mdu.busy_o       = (r_state != S_IDLE);
  assign mdu.result_o     = r_result;

endmodule
